// File: rtl/uart_rx_if.sv
// Receive-side output bundle of uart_rx: received byte, frame status and a state
// debug field. The receiver drives it through the master modport.
interface uart_rx_if;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;

  modport master (
    output data_out, rx_valid, parity_err, frame_err, busy, state_dbg
  );

  modport slave (
    input data_out, rx_valid, parity_err, frame_err, busy, state_dbg
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver, 8 data bits LSB first, optional even parity.
// Define UART_RX_PARITY_EN for the 11-bit frame with a PARITY state; otherwise 10-bit frame.
//
// Valid/ready contract: there is no back-pressure. rx.rx_valid is a one-clk pulse
// that qualifies rx.data_out, rx.parity_err and rx.frame_err. Those three hold
// their value until the next rx_valid pulse.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_clk,
  input  logic in,
  uart_rx_if.master rx
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  state_t          state_q;
  logic            sync1_q;
  logic            sync2_q;
  logic [TW-1:0]   tick_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            ferr_q;
  logic            busy_q;
  // After a break or reset the line must be seen high before a new start edge counts.
  logic            rearm_q;
`ifdef UART_RX_PARITY_EN
  logic            perr_q;
  logic            perr_pend_q;
`endif

  logic            rx_s;
  logic [7:0]      shift_d;
  logic [TW-1:0]   tick_d;

  assign rx_s    = sync2_q;
  assign shift_d = {rx_s, shift_q[7:1]};
  assign tick_d  = tick_q + TW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
      rearm_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
      perr_pend_q <= 1'b0;
`endif
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      valid_q <= 1'b0;
      if (enable_clk) begin
        case (state_q)
          IDLE: begin
            if (rx_s) begin
              rearm_q <= 1'b0;
            end else if (!rearm_q) begin
              state_q <= START;
              tick_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            if (tick_q == MID_TICK) begin
              tick_q <= '0;
              bit_q  <= '0;
              if (!rx_s) begin
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tick_q <= tick_d;
            end
          end
          DATA: begin
            if (tick_q == LAST_TICK) begin
              tick_q  <= '0;
              shift_q <= shift_d;
              if (bit_q == 3'd7) begin
                bit_q <= '0;
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                bit_q <= bit_q + 3'd1;
              end
            end else begin
              tick_q <= tick_d;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_q == LAST_TICK) begin
              tick_q      <= '0;
              perr_pend_q <= rx_s ^ (^shift_q);
              state_q     <= STOP;
            end else begin
              tick_q <= tick_d;
            end
          end
`endif
          STOP: begin
            if (tick_q == LAST_TICK) begin
              tick_q  <= '0;
              ferr_q  <= ~rx_s;
              data_q  <= shift_q;
              valid_q <= 1'b1;
              rearm_q <= ~rx_s;
              state_q <= IDLE;
              busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              perr_q  <= perr_pend_q;
`endif
            end else begin
              tick_q <= tick_d;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx.data_out  = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.busy      = busy_q;
  assign rx.state_dbg = state_q;
`ifdef UART_RX_PARITY_EN
  assign rx.parity_err = perr_q;
`else
  assign rx.parity_err = 1'b0;
`endif

endmodule
